// File: rtl/mult_pkg.sv
// Shared multiplier datapath types.
// Holds the width/term defaults, the accumulator state encoding and the term-count type.
package mult_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_TERMS = 7;
  localparam int DEF_CNT_W = $clog2(DEF_TERMS + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/csa3to2.sv
// WIDTH-bit 3:2 carry-save compressor; purely combinational, zero latency, no handshake.
// The carry vector is pre-shifted left by one and the carry out of the top bit is dropped.
module csa3to2 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  always_comb begin
    sum   = a ^ b ^ d;
    carry = ((a & b) | (a & d) | (b & d)) << 1;
  end

endmodule

// File: rtl/pp_accumulator.sv
// Carry-save accumulator of pre-shifted partial products; result one cycle after the closing beat.
// in_ready is state-only and low from close until the output handshake; the result holds until taken.
module pp_accumulator
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TERMS = DEF_TERMS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_pp,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_sum,
  output logic [$clog2(TERMS+1)-1:0]   out_count,
  output logic                         out_trunc
);

  localparam int CW = $clog2(TERMS + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s_q, c_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] s_base, c_base, s_nxt, c_nxt;
  logic [CW-1:0]    cnt_base, cnt_nxt;
  logic             accept, close;

  // IDLE presents zeros so a new operation starts clean without a clear cycle.
  always_comb begin
    s_base   = (state == IDLE) ? '0 : s_q;
    c_base   = (state == IDLE) ? '0 : c_q;
    cnt_base = (state == IDLE) ? '0 : cnt_q;
    cnt_nxt  = cnt_base + CW'(1);
  end

  csa3to2 #(.WIDTH(WIDTH)) u_csa (
    .a     (s_base),
    .b     (c_base),
    .d     (in_pp),
    .sum   (s_nxt),
    .carry (c_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    close     = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        close    = in_valid && (in_last || (cnt_nxt == CW'(TERMS)));
        if (close)       state_nxt = RESOLVE;
        else if (accept) state_nxt = ACCUM;
      end
      RESOLVE: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      out_sum   <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      if (accept) begin
        s_q   <= s_nxt;
        c_q   <= c_nxt;
        cnt_q <= cnt_nxt;
      end
      if (close) out_trunc <= ~in_last;
      // Single carry-propagate add resolves the redundant form.
      if (state == RESOLVE) begin
        out_sum   <= s_q + c_q;
        out_count <= cnt_q;
      end
    end
  end

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_pp_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pp;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [2:0]  out_count;
  logic        out_trunc;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  pp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pp     (in_pp),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  // Presents one beat for a single edge; caller ensures in_ready is high.
  task automatic drive_beat(input logic [63:0] pp, input logic last);
    in_valid = 1'b1;
    in_pp    = pp;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 64'h0 ||
        out_count !== 3'd0 || out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b vld=%b sum=%h cnt=%0d trunc=%b, need rdy=1 vld=0 sum=0 cnt=0 trunc=0",
               in_ready, out_valid, out_sum, out_count, out_trunc);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_seven_shifts;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive_beat(64'h1 << (8 * i), (i == 6));
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL shift7_resolve: vld=%b rdy=%b, need vld=0 rdy=0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL shift7_latency: vld=%b, need 1", out_valid);
    end
    checks++;
    if (out_sum !== 64'h0001_0101_0101_0101 || out_count !== 3'd7 || out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL shift7_result: sum=%h cnt=%0d trunc=%b, need 0001010101010101 7 0",
               out_sum, out_count, out_trunc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    bit got;
    drive_beat(64'hDEAD_BEEF_0000_0001, 1'b1);
    wait_out(got);
    checks++;
    if (!got || out_sum !== 64'hDEAD_BEEF_0000_0001 || out_count !== 3'd1 || out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL single: got=%b sum=%h cnt=%0d trunc=%b, need 1 deadbeef00000001 1 0",
               got, out_sum, out_count, out_trunc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap;
    bit got;
    drive_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drive_beat(64'h2, 1'b1);
    wait_out(got);
    checks++;
    if (!got || out_sum !== 64'h1 || out_count !== 3'd2) begin
      fails++;
      $display("FAIL wrap: got=%b sum=%h cnt=%0d, need 1 0000000000000001 2", got, out_sum, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_trunc;
    bit got;
    for (int i = 0; i < 7; i++) drive_beat(64'h10, 1'b0);
    // Eighth beat offered immediately and held while the result waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_pp     = 64'h3;
    in_last   = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL trunc_close: rdy=%b vld=%b, need rdy=0 vld=0", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 64'h70 || out_count !== 3'd7 || out_trunc !== 1'b1) begin
      fails++;
      $display("FAIL trunc_result: vld=%b sum=%h cnt=%0d trunc=%b, need 1 70 7 1",
               out_valid, out_sum, out_count, out_trunc);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        fails++;
        $display("FAIL trunc_holdoff: rdy=%b, need 0", in_ready);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(got);
    checks++;
    if (!got || out_sum !== 64'h3 || out_count !== 3'd1 || out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL trunc_next_op: got=%b sum=%h cnt=%0d trunc=%b, need 1 3 1 0",
               got, out_sum, out_count, out_trunc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure;
    bit got;
    out_ready = 1'b0;
    drive_beat(64'hA, 1'b0);
    drive_beat(64'hB, 1'b1);
    wait_out(got);
    checks++;
    if (!got || out_sum !== 64'h15 || out_count !== 3'd2) begin
      fails++;
      $display("FAIL bp_result: got=%b sum=%h cnt=%0d, need 1 15 2", got, out_sum, out_count);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 64'h15) begin
        fails++;
        $display("FAIL bp_hold cycle %0d: vld=%b rdy=%b sum=%h, need 1 0 15", i, out_valid, in_ready, out_sum);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pp     = 64'h4;
    in_last   = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_rdy_before_hs: rdy=%b, need 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_after_hs: rdy=%b vld=%b, need rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(got);
    checks++;
    if (!got || out_sum !== 64'h4 || out_count !== 3'd1) begin
      fails++;
      $display("FAIL bp_clean_start: got=%b sum=%h cnt=%0d, need 1 4 1", got, out_sum, out_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    bit got;
    for (int i = 0; i < 3; i++) drive_beat(64'h100, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 64'h0 ||
        out_count !== 3'd0 || out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: rdy=%b vld=%b sum=%h cnt=%0d trunc=%b, need 1 0 0 0 0",
               in_ready, out_valid, out_sum, out_count, out_trunc);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    drive_beat(64'h5, 1'b0);
    drive_beat(64'h7, 1'b1);
    wait_out(got);
    checks++;
    if (!got || out_sum !== 64'hC || out_count !== 3'd2 || out_trunc !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_op: got=%b sum=%h cnt=%0d trunc=%b, need 1 c 2 0",
               got, out_sum, out_count, out_trunc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pp     = 64'h0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_seven_shifts();
    test_single();
    test_wrap();
    test_trunc();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
